if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit for the five-stage RV32I core. Reads one 32-bit instruction per fetch over the shared byte-wide memory port, assembles it little-endian, and presents `pc_o`/`inst_o` to the IF/ID register, which feeds the decoder. Fetch holds while the pipeline is stalled. It aborts and restarts on a branch/jump redirect from EX. It yields the memory port whenever the memory arbiter reports the MEM stage is using it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.

- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall_i` input 1: pipeline stall from ctrl (includes decoder load-use stall); 1 = IF/ID does not accept.
- `branch_flag_i` input 1: redirect request from EX, one-cycle pulse.
- `branch_target_i` input 32: redirect PC, valid when `branch_flag_i`=1.
- `mem_busy_i` input 1: arbiter grant lost; 1 = fetch must not issue a read this cycle.
- `mem_din_i` input 8: read data byte, valid the cycle after the read is issued.
- `mem_a_o` output 32: byte address of the issued read.
- `mem_rd_o` output 1: read strobe, one cycle per byte.
- `pc_o` output 32: PC of the instruction in `inst_o`.
- `inst_o` output 32: assembled instruction.
- `inst_valid_o` output 1: `pc_o`/`inst_o` hold a complete instruction.
- `if_stall_req_o` output 1: 1 while a fetch is in progress (no valid instruction available).

## Operation
- Reset (rst=1 at an edge), regardless of state:
  - `pc_o`=RESET_PC, `inst_o`=0, `inst_valid_o`=0, `mem_rd_o`=0, `mem_a_o`=0, `if_stall_req_o`=0.
  - Internal fetch PC=RESET_PC, byte counters cleared, pending-read flag cleared.
- States:
  - FETCH: issues and captures bytes.
  - HOLD: instruction valid, waiting for acceptance.
- Leaving reset enters FETCH.
- FETCH:
  - Issue index `iss` runs 0..3.
  - Each cycle with `iss`<4 and `mem_busy_i`=0: `mem_rd_o`=1, `mem_a_o`=fpc+iss, set pending with `pidx`=iss, then `iss`++.
  - With `mem_busy_i`=1: `mem_rd_o`=0 and `iss` is frozen.
  - A pending read from the previous cycle always captures `mem_din_i` into byte `pidx`, whether or not busy is asserted now.
  - Byte 3 captured → next edge: HOLD, `inst_valid_o`=1, `inst_o`={b3,b2,b1,b0}, `pc_o`=fpc.
  - `if_stall_req_o`=1 throughout FETCH.
- HOLD:
  - Outputs stable, no memory reads, `if_stall_req_o`=0.
  - Acceptance is a cycle in HOLD with `stall_i`=0. Next edge: fpc+=4 (mod 2^32), `inst_valid_o`=0, state FETCH with `iss`=0.
  - `stall_i`=1: remain in HOLD indefinitely.
- Redirect (`branch_flag_i`=1) in any state:
  - Next edge: fpc=`branch_target_i`, `inst_valid_o`=0, `iss`=0, pending cleared, state FETCH.
  - Any in-flight byte is discarded.
  - Takes priority over acceptance and over byte completion in the same cycle.
  - Target is used unmodified (no alignment check).
- Address arithmetic is 32-bit wrapping: fpc=32'hFFFF_FFFC fetches FC, FD, FE, FF, then the next PC is 0.

## Timing
- Read protocol: address/strobe in cycle t, data sampled in cycle t+1.
- Unstalled fetch, no busy: reads in cycles 0-3, bytes captured in cycles 1-4, `inst_valid_o`=1 from cycle 5.
- Accept in cycle 5 → next read in cycle 6. Sustained throughput is one instruction per 6 cycles.
- Each busy cycle during issue adds exactly one cycle of latency.
- `mem_rd_o`/`mem_a_o` are registered outputs (asserted the cycle after the issue decision). Implementations may instead drive them combinationally from state, provided the cycle numbering above holds at the ports.
- Redirect in cycle t → first read at fpc=target in cycle t+1.

## Test plan
- Reset release, memory holds 0x93, 0x00, 0x50, 0x00 at 0..3, stall_i=0 → reads at 0,1,2,3 in cycles 0-3; cycle 5 `inst_valid_o`=1, `inst_o`=32'h0050_0093, `pc_o`=0; next read at address 4 in cycle 6.
- HOLD with stall_i=1 for 10 cycles → outputs unchanged, `mem_rd_o`=0 throughout; stall_i drops → read at pc+4 on the following cycle.
- `mem_busy_i`=1 for 3 cycles after the byte-1 read → byte 1 still captured correctly; bytes 2-3 issued after busy drops; valid arrives 3 cycles late with the correct word.
- `branch_flag_i` with target 32'h100 during byte-2 capture → partial word discarded; reads at 0x100..0x103; `pc_o`=32'h100 when valid; no stale bytes in `inst_o`.
- Branch and acceptance in the same HOLD cycle (target 32'h40) → next fetch at 0x40, not pc+4.
- rst asserted mid-fetch with RESET_PC=32'h80 → all outputs at reset values next cycle; fetch restarts at 0x80.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch: gathers four bytes over the shared byte-wide port into one
// little-endian word, holds it for IF/ID, and restarts on reset or redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        if_stall_req_o
);

  // IDLE only covers the single cycle after reset, so the port stays quiet there
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fpc;
  logic [2:0]  r_iss;
  logic        r_pend;
  logic [1:0]  r_pidx;
  logic [23:0] r_bytes;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;

  logic w_issue;
  logic w_done;

  assign w_issue = (r_state == S_FETCH) && !r_iss[2] && !mem_busy_i && !rst;
  assign w_done  = r_pend && (r_pidx == 2'd3);

  assign mem_rd_o       = w_issue;
  assign mem_a_o        = w_issue ? (r_fpc + {30'd0, r_iss[1:0]}) : 32'd0;
  assign pc_o           = r_pc;
  assign inst_o         = r_inst;
  assign inst_valid_o   = r_valid;
  assign if_stall_req_o = (r_state == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_PC;
      r_iss   <= 3'd0;
      r_pend  <= 1'b0;
      r_pidx  <= 2'd0;
      r_bytes <= 24'd0;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= w_issue && !branch_flag_i;
      r_pidx <= r_iss[1:0];
      if (branch_flag_i) begin
        // redirect wins over completion and acceptance; in-flight byte dropped
        r_fpc   <= branch_target_i;
        r_valid <= 1'b0;
        r_iss   <= 3'd0;
        r_state <= S_FETCH;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_FETCH;
          S_FETCH: begin
            if (w_issue) r_iss <= r_iss + 3'd1;
            if (r_pend) begin
              case (r_pidx)
                2'd0:    r_bytes[7:0]   <= mem_din_i;
                2'd1:    r_bytes[15:8]  <= mem_din_i;
                2'd2:    r_bytes[23:16] <= mem_din_i;
                default: r_bytes        <= r_bytes;
              endcase
            end
            if (w_done) begin
              r_inst  <= {mem_din_i, r_bytes};
              r_pc    <= r_fpc;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!stall_i) begin
              r_fpc   <= r_fpc + 32'd4;
              r_valid <= 1'b0;
              r_iss   <= 3'd0;
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench: stimulus pushes expected reads/instructions with their cycle,
// a negedge monitor pops and compares whenever the fetch unit presents one.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rst2, stall, branch, busy;
  logic [31:0] target;
  logic [7:0]  din, din2;
  logic [31:0] mem_a, mem_a2, pc, pc2, inst, inst2;
  logic        mem_rd, mem_rd2, valid, valid2, sreq, sreq2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int F = 0;
  logic prev_valid = 1'b0;

  logic [31:0] exp_ra[$];
  int          exp_rc[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_in[$];
  int          exp_ic[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  if_fetch u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_i(target), .mem_busy_i(busy), .mem_din_i(din),
    .mem_a_o(mem_a), .mem_rd_o(mem_rd), .pc_o(pc), .inst_o(inst),
    .inst_valid_o(valid), .if_stall_req_o(sreq)
  );

  if_fetch #(.RESET_PC(32'h0000_0080)) u_dut80 (
    .clk(clk), .rst(rst2), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_i(target), .mem_busy_i(busy), .mem_din_i(din2),
    .mem_a_o(mem_a2), .mem_rd_o(mem_rd2), .pc_o(pc2), .inst_o(inst2),
    .inst_valid_o(valid2), .if_stall_req_o(sreq2)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h93;  32'h1: return 8'h00;  32'h2: return 8'h50;  32'h3: return 8'h00;
      32'h4: return 8'h13;  32'h5: return 8'h01;  32'h6: return 8'ha0;  32'h7: return 8'h00;
      32'h8: return 8'hb3;  32'h9: return 8'h81;  32'ha: return 8'h20;  32'hb: return 8'h00;
      32'h100: return 8'h6f; 32'h101: return 8'h00; 32'h102: return 8'h00; 32'h103: return 8'h00;
      32'h40: return 8'h37; 32'h41: return 8'h12; 32'h42: return 8'h34; 32'h43: return 8'h12;
      32'h80: return 8'h13; 32'h81: return 8'h05; 32'h82: return 8'h10; 32'h83: return 8'h00;
      32'hffff_fffc: return 8'h11; 32'hffff_fffd: return 8'h22;
      32'hffff_fffe: return 8'h33; 32'hffff_ffff: return 8'h44;
      default: return 8'hc7;
    endcase
  endfunction

  // data valid the cycle after the strobe; idle cycles carry junk
  always @(posedge clk) begin
    din  <= mem_rd  ? mem_byte(mem_a)  : 8'hee;
    din2 <= mem_rd2 ? mem_byte(mem_a2) : 8'hee;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc - F);
    end
  endtask

  task automatic push_rd(input logic [31:0] a, input int n);
    exp_ra.push_back(a);
    exp_rc.push_back(F + n);
  endtask

  task automatic push_in(input logic [31:0] p, input logic [31:0] w, input int n);
    exp_pc.push_back(p);
    exp_in.push_back(w);
    exp_ic.push_back(F + n);
  endtask

  always @(negedge clk) begin
    if (mem_rd) begin
      if (exp_ra.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%h required=none (cycle %0d)", mem_a, cyc - F);
      end else begin
        chk("rd_addr", mem_a, exp_ra.pop_front());
        chk("rd_cycle", cyc, exp_rc.pop_front());
      end
    end
    if (valid && !prev_valid) begin
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst actual=%h required=none (cycle %0d)", inst, cyc - F);
      end else begin
        chk("inst_pc", pc, exp_pc.pop_front());
        chk("inst_word", inst, exp_in.pop_front());
        chk("inst_cycle", cyc, exp_ic.pop_front());
      end
    end
    prev_valid <= valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int n);
    while (cyc < F + n) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_inst"},  inst, 32'h0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_rd"},    {31'd0, mem_rd}, 32'd0);
    chk({tag, "_addr"},  mem_a, 32'h0);
    chk({tag, "_sreq"},  {31'd0, sreq}, 32'd0);
    chk({tag, "_pc80"},  pc2, 32'h80);
    chk({tag, "_inst80"}, inst2, 32'h0);
    chk({tag, "_valid80"}, {31'd0, valid2}, 32'd0);
    chk({tag, "_rd80"},  {31'd0, mem_rd2}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; branch = 1'b0; busy = 1'b0; target = 32'h0;
    repeat (3) tick();
    chk_reset("reset");
    F = cyc + 1;
    rst = 1'b0;

    // first two instructions, back to back
    for (int i = 0; i < 4; i++) push_rd(i, i);
    push_in(32'h0, 32'h0050_0093, 5);
    for (int i = 0; i < 4; i++) push_rd(4 + i, 6 + i);
    push_in(32'h4, 32'h00a0_0113, 11);

    at(7); stall = 1'b1;
    for (int k = 11; k <= 20; k++) begin
      at(k);
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_inst", inst, 32'h00a0_0113);
      chk("hold_pc", pc, 32'h4);
      chk("hold_sreq", {31'd0, sreq}, 32'd0);
    end

    // busy for three cycles after the byte-1 read
    push_rd(32'h8, 22); push_rd(32'h9, 23); push_rd(32'ha, 27); push_rd(32'hb, 28);
    push_in(32'h8, 32'h0020_81b3, 30);
    push_rd(32'hc, 31); push_rd(32'hd, 32); push_rd(32'he, 33); push_rd(32'hf, 34);
    at(21); stall = 1'b0;
    at(24); busy = 1'b1;
    chk("busy_sreq", {31'd0, sreq}, 32'd1);
    at(27); busy = 1'b0;

    // redirect during byte-2 capture
    for (int i = 0; i < 4; i++) push_rd(32'h100 + i, 35 + i);
    push_in(32'h100, 32'h0000_006f, 40);
    at(34); branch = 1'b1; target = 32'h100;
    at(35); branch = 1'b0; stall = 1'b1;

    // redirect and acceptance in the same hold cycle
    for (int i = 0; i < 4; i++) push_rd(32'h40 + i, 43 + i);
    push_in(32'h40, 32'h1234_1237, 48);
    at(42); stall = 1'b0; branch = 1'b1; target = 32'h40;
    at(43); branch = 1'b0; stall = 1'b1;

    // wrap at the top of the address space
    for (int i = 0; i < 4; i++) push_rd(32'hffff_fffc + i, 51 + i);
    push_in(32'hffff_fffc, 32'h4433_2211, 56);
    at(50); branch = 1'b1; target = 32'hffff_fffc;
    at(51); branch = 1'b0;
    for (int i = 0; i < 4; i++) push_rd(i, 59 + i);
    push_in(32'h0, 32'h0050_0093, 64);
    push_rd(32'h4, 65); push_rd(32'h5, 66);
    at(58); stall = 1'b0;

    // reset mid-fetch on both instances
    at(62); rst2 = 1'b0;
    at(63); chk("r80_rd0", {31'd0, mem_rd2}, 32'd1); chk("r80_a0", mem_a2, 32'h80);
    at(65); chk("r80_a2", mem_a2, 32'h82);
    at(67); rst = 1'b1; rst2 = 1'b1;
    at(68); rst = 1'b0; rst2 = 1'b0;
    chk_reset("midrst");
    for (int i = 0; i < 4; i++) push_rd(i, 69 + i);
    push_in(32'h0, 32'h0050_0093, 74);
    for (int k = 0; k < 4; k++) begin
      at(69 + k);
      if (k == 1) stall = 1'b1;
      chk("r80_rd", {31'd0, mem_rd2}, 32'd1);
      chk("r80_addr", mem_a2, 32'h80 + k);
    end
    at(73); chk("r80_notyet", {31'd0, valid2}, 32'd0);
    at(74);
    chk("r80_valid", {31'd0, valid2}, 32'd1);
    chk("r80_pc", pc2, 32'h80);
    chk("r80_inst", inst2, 32'h0010_0513);

    at(80);
    chk("rd_queue_left", exp_ra.size(), 32'd0);
    chk("inst_queue_left", exp_pc.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
